// File: rtl/mem_stage_if.sv
// Bundles the MEM stage pipeline, hazard, forwarding and data-SRAM signals.
// The master view belongs to the MEM stage; the slave view is the surrounding pipeline.
interface mem_stage_if #(
    parameter int ES_TO_MS_BUS_WD = 107,
    parameter int MS_TO_WS_BUS_WD = 70
);
    logic                       ms_stall;
    logic                       ms_flush;
    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [32:0]                ms_to_es_forward_bus;
    logic [37:0]                ms_to_is_forward_bus;
    logic [5:0]                 ms_to_hazard_bus;
    logic [3:0]                 data_sram_we;
    logic [31:0]                data_sram_wdata;
    logic [31:0]                data_sram_rdata;

    modport master (
        input  ms_stall,
        input  ms_flush,
        input  ws_allowin,
        output ms_allowin,
        input  es_to_ms_valid,
        input  es_to_ms_bus,
        output ms_to_ws_valid,
        output ms_to_ws_bus,
        output ms_to_es_forward_bus,
        output ms_to_is_forward_bus,
        output ms_to_hazard_bus,
        output data_sram_we,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        output ms_stall,
        output ms_flush,
        output ws_allowin,
        input  ms_allowin,
        output es_to_ms_valid,
        output es_to_ms_bus,
        input  ms_to_ws_valid,
        input  ms_to_ws_bus,
        input  ms_to_es_forward_bus,
        input  ms_to_is_forward_bus,
        input  ms_to_hazard_bus,
        input  data_sram_we,
        input  data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: holds the EX payload, issues one-shot store writes to data SRAM,
// captures synchronous read data and produces the aligned/extended WB result.
module mem_stage (
    input  logic         clk,
    input  logic         resetn,
    mem_stage_if.master  bus_if
);
    localparam int ES_W = 107;

    // Registered state
    logic            ms_valid_q,  ms_valid_d;
    logic [ES_W-1:0] bus_q,       bus_d;
    logic [31:0]     rdata_buf_q, rdata_buf_d;
    logic            first_q,     first_d;

    // Decoded payload fields and combinational results
    logic        res_from_mem_s;
    logic        gr_we_s;
    logic        mem_we_s;
    logic [4:0]  dest_s;
    logic        unsigned_ld_s;
    logic [1:0]  st_size_s;
    logic [31:0] alu_result_s;
    logic [31:0] rkd_value_s;
    logic [31:0] pc_s;
    logic        ms_allowin_s;
    logic        mem_we_act_s;
    logic [31:0] rdata_eff_s;
    logic [31:0] load_result_s;
    logic [31:0] final_result_s;
    logic        fwd_en_s;
    logic        has_ld_s;
    logic [3:0]  sram_we_s;

    function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] a_lo);
        logic [3:0] strobe;
        case (size)
            2'b00:   strobe = 4'b0001 << a_lo;
            2'b01:   strobe = a_lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   strobe = 4'b1111;
            default: strobe = 4'b0000;
        endcase
        return strobe;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] rkd);
        logic [31:0] data;
        case (size)
            2'b00:   data = {4{rkd[7:0]}};
            2'b01:   data = {2{rkd[15:0]}};
            2'b10:   data = rkd;
            default: data = rkd;
        endcase
        return data;
    endfunction

    // Byte/half lanes are picked by the low address bits, then zero- or sign-extended.
    function automatic logic [31:0] load_align(input logic [1:0] size, input logic uns,
                                               input logic [1:0] a_lo, input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [31:0] result;
        shifted = rdata >> {a_lo, 3'b000};
        half    = a_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   result = uns ? {24'h000000, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   result = uns ? {16'h0000, half} : {{16{half[15]}}, half};
            2'b10:   result = rdata;
            default: result = rdata;
        endcase
        return result;
    endfunction

    assign res_from_mem_s = bus_q[106];
    assign gr_we_s        = bus_q[105];
    assign mem_we_s       = bus_q[104];
    assign dest_s         = bus_q[103:99];
    assign unsigned_ld_s  = bus_q[98];
    assign st_size_s      = bus_q[97:96];
    assign alu_result_s   = bus_q[95:64];
    assign rkd_value_s    = bus_q[63:32];
    assign pc_s           = bus_q[31:0];

    assign ms_allowin_s = (!ms_valid_q || bus_if.ws_allowin) && !bus_if.ms_stall;

    // Next-state: flush beats load; the read buffer tracks SRAM data only in the entry cycle.
    always_comb begin
        ms_valid_d  = ms_valid_q;
        bus_d       = bus_q;
        first_d     = 1'b0;
        rdata_buf_d = rdata_buf_q;
        if (first_q) begin
            rdata_buf_d = bus_if.data_sram_rdata;
        end else begin
            rdata_buf_d = rdata_buf_q;
        end
        if (bus_if.ms_flush) begin
            ms_valid_d = 1'b0;
            bus_d      = {ES_W{1'b0}};
            first_d    = 1'b0;
        end else if (ms_allowin_s) begin
            ms_valid_d = bus_if.es_to_ms_valid;
            first_d    = bus_if.es_to_ms_valid;
            if (bus_if.es_to_ms_valid) begin
                bus_d = bus_if.es_to_ms_bus;
            end else begin
                bus_d = bus_q;
            end
        end else begin
            ms_valid_d = ms_valid_q;
            bus_d      = bus_q;
            first_d    = 1'b0;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q  <= 1'b0;
            bus_q       <= {ES_W{1'b0}};
            rdata_buf_q <= 32'h0000_0000;
            first_q     <= 1'b0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            bus_q       <= bus_d;
            rdata_buf_q <= rdata_buf_d;
            first_q     <= first_d;
        end
    end

    // A store fires only in its entry cycle, so a stalled store never writes twice.
    assign mem_we_act_s   = ms_valid_q && mem_we_s && first_q && !bus_if.ms_flush;
    assign rdata_eff_s    = first_q ? bus_if.data_sram_rdata : rdata_buf_q;
    assign load_result_s  = load_align(st_size_s, unsigned_ld_s, alu_result_s[1:0], rdata_eff_s);
    assign fwd_en_s       = ms_valid_q && gr_we_s && (dest_s != 5'd0);
    assign has_ld_s       = ms_valid_q && res_from_mem_s;

    // Result select and store strobe gating.
    always_comb begin
        final_result_s = alu_result_s;
        sram_we_s      = 4'b0000;
        if (res_from_mem_s) begin
            final_result_s = load_result_s;
        end else begin
            final_result_s = alu_result_s;
        end
        if (mem_we_act_s) begin
            sram_we_s = store_strobe(st_size_s, alu_result_s[1:0]);
        end else begin
            sram_we_s = 4'b0000;
        end
    end

    assign bus_if.ms_allowin           = ms_allowin_s;
    assign bus_if.ms_to_ws_valid       = ms_valid_q;
    assign bus_if.ms_to_ws_bus         = {gr_we_s, dest_s, final_result_s, pc_s};
    assign bus_if.ms_to_es_forward_bus = {mem_we_act_s, alu_result_s};
    assign bus_if.ms_to_is_forward_bus = {fwd_en_s, dest_s, final_result_s};
    assign bus_if.ms_to_hazard_bus     = {dest_s, has_ld_s};
    assign bus_if.data_sram_we         = sram_we_s;
    assign bus_if.data_sram_wdata      = store_data(st_size_s, rkd_value_s);

endmodule
